// File: rtl/traffic_light_pkg.sv
// Shared state encoding and default timing for the multi-direction traffic controller.
// TRAFFIC_NIGHT_FLASH_EN adds the FLASH state to the encoding.
package traffic_light_pkg;

    localparam int DEF_N_DIR      = 2;
    localparam int DEF_G_CYC      = 8;
    localparam int DEF_Y_CYC      = 3;
    localparam int DEF_AR_CYC     = 2;
    localparam int DEF_MIN_G      = 2;
    localparam int DEF_FLASH_HALF = 4;

    typedef enum logic [1:0] {
        ST_GREEN  = 2'd0,
        ST_YELLOW = 2'd1,
        ST_ALLRED = 2'd2
`ifdef TRAFFIC_NIGHT_FLASH_EN
        , ST_FLASH = 2'd3
`endif
    } state_e;

    function automatic int max4(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

// File: rtl/phase_timer.sv
// Loadable down-counter for phase durations; done flags the last cycle of a phase.
// Zero means "never loaded" and holds without wrapping.
module phase_timer #(
    parameter int TW = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load_i,
    input  logic [TW-1:0] load_val_i,
    output logic [TW-1:0] cnt_o,
    output logic          done_o
);

    logic [TW-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= load_val_i;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - TW'(1);
        end
    end

    assign cnt_o  = cnt_q;
    assign done_o = (cnt_q == TW'(1));

endmodule

// File: rtl/traffic_light_multi.sv
// Round-robin N-direction traffic light controller with request-driven early yellow.
// Define TRAFFIC_NIGHT_FLASH_EN to build in the night FLASH state.
module traffic_light_multi
    import traffic_light_pkg::*;
#(
    parameter int N_DIR      = DEF_N_DIR,
    parameter int G_CYC      = DEF_G_CYC,
    parameter int Y_CYC      = DEF_Y_CYC,
    parameter int AR_CYC     = DEF_AR_CYC,
    parameter int MIN_G      = DEF_MIN_G,
    parameter int FLASH_HALF = DEF_FLASH_HALF
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [N_DIR-1:0]         pass,
    input  logic                     night,
    output logic [N_DIR-1:0]         R,
    output logic [N_DIR-1:0]         G,
    output logic [N_DIR-1:0]         Y,
    output logic [$clog2(N_DIR)-1:0] dir
);

    localparam int DW = $clog2(N_DIR);
    localparam int TW = $clog2(max4(G_CYC, Y_CYC, AR_CYC, FLASH_HALF) + 1);
    typedef logic [TW-1:0] tmr_t;
    localparam tmr_t T_G   = tmr_t'(G_CYC);
    localparam tmr_t T_Y   = tmr_t'(Y_CYC);
    localparam tmr_t T_AR  = tmr_t'(AR_CYC);
    // Remaining count at which MIN_G green cycles have elapsed.
    localparam tmr_t T_CUT = tmr_t'(G_CYC - MIN_G + 1);

    state_e           state_q, state_d;
    logic [DW-1:0]    dir_q, dir_d;
    logic [N_DIR-1:0] pend_q, pend_d;
    logic [N_DIR-1:0] dir_oh, oh_d, r_d, g_d, y_d;
    logic             req_other;
    logic             ld;
    tmr_t             ld_val, tmr;
    logic             tdone;

`ifdef TRAFFIC_NIGHT_FLASH_EN
    localparam tmr_t T_F = tmr_t'(FLASH_HALF);
    logic flash_q, flash_d;
    logic aft_q, aft_d;
`else
    logic unused_night;
    assign unused_night = night;
`endif

    phase_timer #(.TW(TW)) u_tmr (
        .clk       (clk),
        .rst_n     (rst_n),
        .load_i    (ld),
        .load_val_i(ld_val),
        .cnt_o     (tmr),
        .done_o    (tdone)
    );

    function automatic logic [DW-1:0] next_dir(input logic [DW-1:0] cur,
                                               input logic [N_DIR-1:0] p);
        int idx;
        next_dir = (cur == DW'(N_DIR - 1)) ? '0 : cur + DW'(1);
        // Scan farthest first so the nearest pending direction wins.
        for (int i = N_DIR - 1; i >= 1; i--) begin
            idx = (int'(cur) + i) % N_DIR;
            if (p[idx]) next_dir = DW'(idx);
        end
    endfunction

    assign dir_oh    = N_DIR'(1) << dir_q;
    assign req_other = |(pend_q & ~dir_oh);

    always_comb begin
        state_d = state_q;
        dir_d   = dir_q;
        ld      = 1'b0;
        ld_val  = '0;
        pend_d  = pend_q | (pass & ~((state_q == ST_GREEN) ? dir_oh : '0));
`ifdef TRAFFIC_NIGHT_FLASH_EN
        flash_d = flash_q;
        aft_d   = aft_q;
`endif
        case (state_q)
            ST_GREEN: begin
                if (tmr == '0) begin
                    ld     = 1'b1;
                    ld_val = T_G;
                end else if (tdone || (req_other && tmr <= T_CUT)) begin
                    state_d = ST_YELLOW;
                    ld      = 1'b1;
                    ld_val  = T_Y;
                end
            end
            ST_YELLOW: begin
                if (tdone) begin
                    state_d = ST_ALLRED;
                    ld      = 1'b1;
                    ld_val  = T_AR;
                end
            end
            ST_ALLRED: begin
                if (tdone) begin
                    state_d = ST_GREEN;
                    ld      = 1'b1;
                    ld_val  = T_G;
                    dir_d   = next_dir(dir_q, pend_q);
`ifdef TRAFFIC_NIGHT_FLASH_EN
                    if (aft_q) dir_d = '0;
                    aft_d = 1'b0;
`endif
                end
            end
`ifdef TRAFFIC_NIGHT_FLASH_EN
            ST_FLASH: begin
                if (!night) begin
                    state_d = ST_ALLRED;
                    ld      = 1'b1;
                    ld_val  = T_AR;
                    aft_d   = 1'b1;
                end else if (tdone) begin
                    ld      = 1'b1;
                    ld_val  = T_F;
                    flash_d = ~flash_q;
                end
            end
`endif
            default: ;
        endcase
`ifdef TRAFFIC_NIGHT_FLASH_EN
        if (night && state_q != ST_FLASH) begin
            state_d = ST_FLASH;
            ld      = 1'b1;
            ld_val  = T_F;
            flash_d = 1'b1;
            dir_d   = '0;
        end
        if (state_q == ST_FLASH || state_d == ST_FLASH) pend_d = '0;
`endif
        // Entering green clears the served request, overriding a same-cycle set.
        if (state_d == ST_GREEN && state_q != ST_GREEN) pend_d[dir_d] = 1'b0;

        oh_d = N_DIR'(1) << dir_d;
        r_d  = '1;
        g_d  = '0;
        y_d  = '0;
        case (state_d)
            ST_GREEN:  begin g_d = oh_d; r_d = ~oh_d; end
            ST_YELLOW: begin y_d = oh_d; r_d = ~oh_d; end
`ifdef TRAFFIC_NIGHT_FLASH_EN
            ST_FLASH:  begin r_d = '0; y_d = {N_DIR{flash_d}}; end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_GREEN;
            dir_q   <= '0;
            pend_q  <= '0;
            R       <= ~N_DIR'(1);
            G       <= N_DIR'(1);
            Y       <= '0;
`ifdef TRAFFIC_NIGHT_FLASH_EN
            flash_q <= 1'b0;
            aft_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            dir_q   <= dir_d;
            pend_q  <= pend_d;
            R       <= r_d;
            G       <= g_d;
            Y       <= y_d;
`ifdef TRAFFIC_NIGHT_FLASH_EN
            flash_q <= flash_d;
            aft_q   <= aft_d;
`endif
        end
    end

    assign dir = dir_q;

endmodule

// File: tb/tb_traffic_light_multi.sv
// Scoreboard bench: stimulus queues hand-computed lamp patterns per edge, a monitor compares.
// Exercises 2- and 4-direction instances; FLASH checks only when TRAFFIC_NIGHT_FLASH_EN is set.
module tb_traffic_light_multi;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       night = 1'b0;
    logic [1:0] pass2 = '0;
    logic [3:0] pass4 = '0;
    logic [1:0] R2, G2, Y2;
    logic       dir2;
    logic [3:0] R4, G4, Y4;
    logic [1:0] dir4;

    always #5 clk = ~clk;

    traffic_light_multi u_dut2 (
        .clk(clk), .rst_n(rst_n), .pass(pass2), .night(night),
        .R(R2), .G(G2), .Y(Y2), .dir(dir2)
    );

    traffic_light_multi #(.N_DIR(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .pass(pass4), .night(night),
        .R(R4), .G(G4), .Y(Y4), .dir(dir4)
    );

    typedef struct {
        int         id;
        logic [7:0] r, g, y;
        int         d;
        string      tag;
    } exp_t;

    exp_t q[$];
    int   n_chk = 0;
    int   n_pass = 0;
    event chk_ev;

    // 'G' green, 'Y' yellow, 'A' all red, 'H' flash lamps on, 'L' flash lamps off.
    function automatic exp_t mk(input int id, input byte ph, input int d, input string tag);
        exp_t       e;
        logic [7:0] mask, oh;
        mask  = (id == 0) ? 8'h03 : 8'h0f;
        oh    = (d >= 0) ? (8'(1) << d) : 8'h00;
        e.id  = id;
        e.d   = d;
        e.tag = tag;
        e.r   = mask;
        e.g   = 8'h00;
        e.y   = 8'h00;
        case (ph)
            "G": begin e.g = oh; e.r = mask & ~oh; end
            "Y": begin e.y = oh; e.r = mask & ~oh; end
            "H": begin e.r = 8'h00; e.y = mask; end
            "L": e.r = 8'h00;
            default: ;
        endcase
        return e;
    endfunction

    task automatic step(input int id, input byte ph, input int d, input string tag);
        q.push_back(mk(id, ph, d, tag));
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic run(input int id, input byte ph, input int d, input int n, input string tag);
        for (int i = 0; i < n; i++) step(id, ph, d, tag);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        pass2 = '0;
        pass4 = '0;
        night = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin : monitor
        exp_t       e;
        logic [7:0] ar, ag, ay;
        int         ad;
        forever begin
            @(posedge clk or chk_ev);
            #1;
            if (q.size() != 0) begin
                e = q.pop_front();
                if (e.id == 0) begin
                    ar = {6'b0, R2}; ag = {6'b0, G2}; ay = {6'b0, Y2}; ad = int'(dir2);
                end else begin
                    ar = {4'b0, R4}; ag = {4'b0, G4}; ay = {4'b0, Y4}; ad = int'(dir4);
                end
                n_chk++;
                if (ar == e.r && ag == e.g && ay == e.y && (e.d < 0 || ad == e.d))
                    n_pass++;
                else
                    $display("FAIL %s: got R=%b G=%b Y=%b dir=%0d, want R=%b G=%b Y=%b dir=%0d",
                             e.tag, ar, ag, ay, ad, e.r, e.g, e.y, e.d);
            end
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stim
        @(negedge clk);
        // Reset state held across an edge, then default rotation.
        step(0, "G", 0, "rst_hold");
`ifndef TRAFFIC_NIGHT_FLASH_EN
        night = 1'b1;
`endif
        rst_n = 1'b1;
        run(0, "G", 0, 8, "rot_g0");
        run(0, "Y", 0, 3, "rot_y0");
        run(0, "A", 0, 2, "rot_ar0");
        run(0, "G", 1, 8, "rot_g1");
        run(0, "Y", 1, 3, "rot_y1");
        run(0, "A", 1, 2, "rot_ar1");
        step(0, "G", 0, "rot_wrap");
        night = 1'b0;

        // Request at edge 4 cuts green; own-direction request is ignored.
        do_reset();
        run(0, "G", 0, 3, "cut_pre");
        pass2 = 2'b10;
        step(0, "G", 0, "cut_req");
        pass2 = 2'b00;
        run(0, "Y", 0, 3, "cut_y0");
        run(0, "A", 0, 2, "cut_ar0");
        step(0, "G", 1, "cut_g1");
        pass2 = 2'b10;
        step(0, "G", 1, "own_ign");
        pass2 = 2'b00;
        run(0, "G", 1, 6, "own_g1");
        run(0, "Y", 1, 3, "own_y1");
        run(0, "A", 1, 2, "own_ar1");
        run(0, "G", 0, 8, "own_full_g0");
        step(0, "Y", 0, "own_y0");

        // Request at edge 1 held until MIN_G elapsed.
        do_reset();
        pass2 = 2'b10;
        step(0, "G", 0, "hold_e1");
        pass2 = 2'b00;
        step(0, "G", 0, "hold_e2");
        run(0, "Y", 0, 3, "held_y0");
        run(0, "A", 0, 2, "held_ar0");
        step(0, "G", 1, "held_g1");

        // Async reset mid all-red of direction 1.
        do_reset();
        run(0, "G", 0, 8, "ar_g0");
        run(0, "Y", 0, 3, "ar_y0");
        run(0, "A", 0, 2, "ar_ar0");
        run(0, "G", 1, 8, "ar_g1");
        run(0, "Y", 1, 3, "ar_y1");
        step(0, "A", 1, "ar_mid");
        #2;
        rst_n = 1'b0;
        q.push_back(mk(0, "G", 0, "async_rst"));
        ->chk_ev;
        @(negedge clk);
        rst_n = 1'b1;
        step(0, "G", 0, "post_rst");

`ifdef TRAFFIC_NIGHT_FLASH_EN
        // Night flash entered mid-yellow, then released.
        do_reset();
        run(0, "G", 0, 8, "fl_g0");
        run(0, "Y", 0, 2, "fl_y0");
        night = 1'b1;
        run(0, "H", -1, 4, "fl_on");
        step(0, "L", -1, "fl_off");
        pass2 = 2'b10;
        step(0, "L", -1, "fl_off_pass");
        pass2 = 2'b00;
        run(0, "L", -1, 2, "fl_off");
        step(0, "H", -1, "fl_on2");
        night = 1'b0;
        run(0, "A", 0, 2, "fl_ar");
        run(0, "G", 0, 8, "fl_g0_full");
        step(0, "Y", 0, "fl_y0_after");
`endif

        // Four directions: skip to 3, ignore own request, pend cleared on service.
        do_reset();
        step(1, "G", 0, "n4_g0");
        pass4 = 4'b0001;
        step(1, "G", 0, "n4_own0");
        pass4 = 4'b0000;
        run(1, "G", 0, 2, "n4_g0");
        pass4 = 4'b1000;
        step(1, "G", 0, "n4_req3");
        pass4 = 4'b0000;
        run(1, "Y", 0, 3, "n4_y0");
        run(1, "A", 0, 2, "n4_ar0");
        run(1, "G", 3, 8, "n4_g3");
        run(1, "Y", 3, 3, "n4_y3");
        run(1, "A", 3, 2, "n4_ar3");
        run(1, "G", 0, 4, "n4_wrap_g0");

        @(posedge clk);
        #3;
        if (q.size() != 0) begin
            n_chk++;
            $display("FAIL drain: %0d entries left, want 0", q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/traffic_light_multi.md
TRAFFIC_LIGHT_MULTI -- requirements
Module: traffic_light_multi

Interface
REQ-001 Parameter N_DIR, default 2, number of directions (legal range 2..8).
REQ-002 Parameter G_CYC, default 8, green duration in cycles (at least 2).
REQ-003 Parameter Y_CYC, default 3, yellow duration in cycles (at least 1).
REQ-004 Parameter AR_CYC, default 2, all-red clearance in cycles (at least 1).
REQ-005 Parameter MIN_G, default 2, minimum green cycles before a request may cut green short (1..G_CYC).
REQ-006 Parameter FLASH_HALF, default 4, night-flash half-period in cycles.
REQ-007 clk  in  1  single system clock; all state changes on the rising edge.
REQ-008 rst_n  in  1  asynchronous, active-low reset.
REQ-009 pass  in  N_DIR  per-direction service request; bit k requests green for direction k.
REQ-010 night  in  1  night-flash mode request.
REQ-011 R  out  N_DIR  red lamp per direction.
REQ-012 G  out  N_DIR  green lamp per direction.
REQ-013 Y  out  N_DIR  yellow lamp per direction.
REQ-014 dir  out  clog2(N_DIR)  index of the direction currently served.

Function
REQ-015 The controller SHALL be an FSM with states GREEN, YELLOW, ALLRED and FLASH.
REQ-016 Outputs SHALL be a decode of registered state only, with no input-to-output combinational path.
REQ-017 In GREEN, G[dir]=1 and all other R bits=1; in YELLOW, Y[dir]=1 and all other R bits=1; in ALLRED, all R bits=1.
REQ-018 Exactly one lamp per direction SHALL be lit in GREEN, YELLOW and ALLRED.
REQ-019 GREEN SHALL last G_CYC cycles, YELLOW Y_CYC cycles and ALLRED AR_CYC cycles, then the FSM SHALL enter GREEN for the next direction.
REQ-020 The next direction SHALL be the first pending direction after dir in round-robin order; if none is pending, it SHALL be (dir+1) mod N_DIR, wrapping from N_DIR-1 to 0.
REQ-021 A pass[k] seen at a rising edge SHALL set pend[k], except when k equals dir and the FSM is in GREEN; that request SHALL be ignored.
REQ-022 pend[k] SHALL clear on the cycle direction k enters GREEN.
REQ-023 A set in the same cycle as a clear for the same k SHALL leave pend[k] clear.
REQ-024 In GREEN, if any pend[j] with j not equal to dir is set and elapsed green is at least MIN_G cycles, YELLOW SHALL start on the next cycle.
REQ-025 A request arriving before MIN_G SHALL be held and SHALL take effect once MIN_G cycles have elapsed.
REQ-026 The timer SHALL reload on every state change; counters SHALL never wrap inside a state.

Reset
REQ-027 While rst_n=0 and asynchronously on its assertion: state=GREEN, dir=0, timer=0, pend=0, G=...01, R=~...01, Y=0.
REQ-028 Reset asserted mid-phase SHALL abort the phase immediately.
REQ-029 After rst_n deasserts, the first rising edge SHALL count as green cycle 1 of direction 0.

Configuration
REQ-030 Macro TRAFFIC_NIGHT_FLASH_EN SHALL compile the FLASH state in or out.
REQ-031 With the macro defined, night=1 SHALL force FLASH on the next edge from any state and SHALL take priority over pass.
REQ-032 In FLASH, R=0, G=0 and all Y bits SHALL toggle together every FLASH_HALF cycles, starting at 1; pend SHALL be cleared and pass ignored.
REQ-033 With the macro defined, night=0 in FLASH SHALL lead to ALLRED for AR_CYC cycles, then GREEN of direction 0.
REQ-034 Without the macro, night SHALL be ignored and the FLASH state SHALL not exist.

Structure
REQ-035 Package traffic_light_pkg SHALL hold the state enum and the default timing constants.
REQ-036 Sub-module phase_timer SHALL be a loadable down-counter with a done flag, instanced once.
REQ-037 The round-robin next-direction select SHALL be a function in the top module.

Verification
REQ-038 Defaults, pass=0: G[0] for edges 1-8, Y[0] for 9-11, all red for 12-13, G[1] for 14-21, giving a 26-cycle rotation, then G[0] at edge 27.
REQ-039 pass[1] pulsed at edge 4 of G[0]: Y[0] SHALL start at edge 5, all red at 8-9, G[1] at edge 10.
REQ-040 pass[1] pulsed at edge 1 with MIN_G=2: held; Y[0] SHALL start at edge 3.
REQ-041 N_DIR=4, pass[3] at edge 5: dir SHALL go 0 to 3, skipping 1 and 2; pend[3]=0 once G[3]=1; pass[0] during G[0] SHALL be ignored.
REQ-042 With TRAFFIC_NIGHT_FLASH_EN, night=1 mid-YELLOW: Y SHALL be all ones for 4 cycles, then all zeros for 4; on night=0, all red for 2 cycles, then G[0].
REQ-043 rst_n pulsed low mid-ALLRED of direction 1: G[0]=1 and dir=0 SHALL hold before the next clk edge.
